// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue stage: ALU operation codes,
// RV32I major opcodes and the decoder result record.
package alu_issue_pkg;

  localparam logic [3:0] ALUOP_AND = 4'd0;
  localparam logic [3:0] ALUOP_OR  = 4'd1;
  localparam logic [3:0] ALUOP_ADD = 4'd2;
  localparam logic [3:0] ALUOP_SLL = 4'd3;
  localparam logic [3:0] ALUOP_SRL = 4'd4;
  localparam logic [3:0] ALUOP_SUB = 4'd5;
  localparam logic [3:0] ALUOP_SRA = 4'd6;
  localparam logic [3:0] ALUOP_SLT = 4'd7;
  localparam logic [3:0] ALUOP_EQ  = 4'd8;
  localparam logic [3:0] ALUOP_NE  = 4'd9;
  localparam logic [3:0] ALUOP_LT  = 4'd10;
  localparam logic [3:0] ALUOP_GE  = 4'd11;
  localparam logic [3:0] ALUOP_XOR = 4'd12;

  typedef enum logic [3:0] {
    OP_AND = ALUOP_AND, OP_OR = ALUOP_OR, OP_ADD = ALUOP_ADD, OP_SLL = ALUOP_SLL,
    OP_SRL = ALUOP_SRL, OP_SUB = ALUOP_SUB, OP_SRA = ALUOP_SRA, OP_SLT = ALUOP_SLT,
    OP_EQ  = ALUOP_EQ,  OP_NE  = ALUOP_NE,  OP_LT  = ALUOP_LT,  OP_GE  = ALUOP_GE,
    OP_XOR = ALUOP_XOR
  } alu_op_e;

  localparam logic [6:0] RV_OP     = 7'b0110011;
  localparam logic [6:0] RV_OP_IMM = 7'b0010011;
  localparam logic [6:0] RV_LOAD   = 7'b0000011;
  localparam logic [6:0] RV_STORE  = 7'b0100011;
  localparam logic [6:0] RV_BRANCH = 7'b1100011;
  localparam logic [6:0] RV_LUI    = 7'b0110111;
  localparam logic [6:0] RV_AUIPC  = 7'b0010111;
  localparam logic [6:0] RV_JAL    = 7'b1101111;
  localparam logic [6:0] RV_JALR   = 7'b1100111;

  typedef enum logic [1:0] {SRCA_ZERO = 2'd0, SRCA_RS1 = 2'd1, SRCA_PC = 2'd2} srca_sel_e;
  typedef enum logic [1:0] {SRCB_ZERO = 2'd0, SRCB_RS2 = 2'd1, SRCB_IMM = 2'd2, SRCB_FOUR = 2'd3} srcb_sel_e;

  typedef struct packed {
    alu_op_e     op;
    srca_sel_e   a_sel;
    srcb_sel_e   b_sel;
    logic [31:0] imm;
    logic        illegal;
  } decode_t;

  localparam decode_t DEC_ILLEGAL = '{op: OP_AND, a_sel: SRCA_ZERO, b_sel: SRCB_ZERO,
                                      imm: 32'd0, illegal: 1'b1};

endpackage

// File: rtl/alu_issue_if.sv
// Handshake bus of the ALU issue stage: upstream instruction side and
// downstream registered-operand side.
interface alu_issue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              instr;
  logic [DATA_WIDTH-1:0]    pc;
  logic [DATA_WIDTH-1:0]    rs1_data;
  logic [DATA_WIDTH-1:0]    rs2_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     out_illegal;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, SrcA, SrcB, Operation, out_illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, SrcA, SrcB, Operation, out_illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I decoder: instruction word to ALU operation, operand
// selects, sign-extended immediate and illegal flag.
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        alt_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_u_s;
  logic [31:0] shamt_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign alt_s    = instr[30];
  assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u_s  = {instr[31:12], 12'h000};
  assign shamt_s  = {27'd0, instr[24:20]};

  // Opcode/funct3 decode; unmapped encodings fall back to the illegal record.
  always_comb begin
    dec = '{op: OP_AND, a_sel: SRCA_ZERO, b_sel: SRCB_ZERO, imm: 32'd0, illegal: 1'b0};
    case (opcode_s)
      RV_OP: begin
        dec.a_sel = SRCA_RS1;
        dec.b_sel = SRCB_RS2;
        case (funct3_s)
          3'b000:  dec.op = alt_s ? OP_SUB : OP_ADD;
          3'b001:  dec.op = OP_SLL;
          3'b010:  dec.op = OP_SLT;
          3'b100:  dec.op = OP_XOR;
          3'b101:  dec.op = alt_s ? OP_SRA : OP_SRL;
          3'b110:  dec.op = OP_OR;
          3'b111:  dec.op = OP_AND;
          default: dec = DEC_ILLEGAL;
        endcase
      end
      RV_OP_IMM: begin
        dec.a_sel = SRCA_RS1;
        dec.b_sel = SRCB_IMM;
        dec.imm   = imm_i_s;
        case (funct3_s)
          3'b000:  dec.op = OP_ADD;
          3'b001:  begin dec.op = OP_SLL; dec.imm = shamt_s; end
          3'b010:  dec.op = OP_SLT;
          3'b100:  dec.op = OP_XOR;
          3'b101:  begin dec.op = alt_s ? OP_SRA : OP_SRL; dec.imm = shamt_s; end
          3'b110:  dec.op = OP_OR;
          3'b111:  dec.op = OP_AND;
          default: dec = DEC_ILLEGAL;
        endcase
      end
      RV_LOAD:  dec = '{op: OP_ADD, a_sel: SRCA_RS1, b_sel: SRCB_IMM, imm: imm_i_s, illegal: 1'b0};
      RV_STORE: dec = '{op: OP_ADD, a_sel: SRCA_RS1, b_sel: SRCB_IMM, imm: imm_s_s, illegal: 1'b0};
      RV_BRANCH: begin
        dec.a_sel = SRCA_RS1;
        dec.b_sel = SRCB_RS2;
        case (funct3_s)
          3'b000:  dec.op = OP_EQ;
          3'b001:  dec.op = OP_NE;
          3'b100:  dec.op = OP_LT;
          3'b101:  dec.op = OP_GE;
          default: dec = DEC_ILLEGAL;
        endcase
      end
      RV_LUI:   dec = '{op: OP_ADD, a_sel: SRCA_ZERO, b_sel: SRCB_IMM, imm: imm_u_s, illegal: 1'b0};
      RV_AUIPC: dec = '{op: OP_ADD, a_sel: SRCA_PC, b_sel: SRCB_IMM, imm: imm_u_s, illegal: 1'b0};
      RV_JAL, RV_JALR:
                dec = '{op: OP_ADD, a_sel: SRCA_PC, b_sel: SRCB_FOUR, imm: 32'd0, illegal: 1'b0};
      default:  dec = DEC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32I instruction and registers ALU operands
// behind a valid/ready handshake. Define ALU_ISSUE_FWD_EN to enable EX/MEM forwarding.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
)(
  input  logic                  clk,
  input  logic                  reset,
  alu_issue_if.slave            bus,
  input  logic                  flush,
  input  logic                  fwd_we,
  input  logic [4:0]            fwd_rd,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  output logic [15:0]           issue_count
);

  decode_t                  dec_s;
  logic [DATA_WIDTH-1:0]    rs1_s;
  logic [DATA_WIDTH-1:0]    rs2_s;
  logic [DATA_WIDTH-1:0]    imm_s;
  logic [DATA_WIDTH-1:0]    srca_s;
  logic [DATA_WIDTH-1:0]    srcb_s;
  logic                     in_ready_s;
  logic                     accept_s;
  logic                     out_valid_r;
  logic [DATA_WIDTH-1:0]    srca_r;
  logic [DATA_WIDTH-1:0]    srcb_r;
  logic [OPCODE_LENGTH-1:0] op_r;
  logic                     illegal_r;
  logic [15:0]              count_r;

  alu_op_decode u_decode (
    .instr (bus.instr),
    .dec   (dec_s)
  );

`ifdef ALU_ISSUE_FWD_EN
  // Substitute the in-flight EX/MEM result for a stale register-file read; x0 is never forwarded.
  always_comb begin
    rs1_s = bus.rs1_data;
    rs2_s = bus.rs2_data;
    if (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == bus.instr[19:15])) begin
      rs1_s = fwd_data;
    end else begin
      rs1_s = bus.rs1_data;
    end
    if (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == bus.instr[24:20])) begin
      rs2_s = fwd_data;
    end else begin
      rs2_s = bus.rs2_data;
    end
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{fwd_we, fwd_rd, fwd_data};
  assign rs1_s = bus.rs1_data;
  assign rs2_s = bus.rs2_data;
`endif

  assign imm_s = DATA_WIDTH'($signed(dec_s.imm));

  // Operand multiplexers driven by the decoder selects.
  always_comb begin
    srca_s = '0;
    srcb_s = '0;
    case (dec_s.a_sel)
      SRCA_RS1: srca_s = rs1_s;
      SRCA_PC:  srca_s = bus.pc;
      default:  srca_s = '0;
    endcase
    case (dec_s.b_sel)
      SRCB_RS2:  srcb_s = rs2_s;
      SRCB_IMM:  srcb_s = imm_s;
      SRCB_FOUR: srcb_s = DATA_WIDTH'(4);
      default:   srcb_s = '0;
    endcase
  end

  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s && !flush;

  // Output register: flush wins over accept and handshake; payload only changes on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      srca_r      <= '0;
      srcb_r      <= '0;
      op_r        <= '0;
      illegal_r   <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      srca_r      <= srca_s;
      srcb_r      <= srcb_s;
      op_r        <= OPCODE_LENGTH'(dec_s.op);
      illegal_r   <= dec_s.illegal;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Saturating count of accepted instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 16'd0;
    end else if (accept_s && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.SrcA        = srca_r;
  assign bus.SrcB        = srcb_r;
  assign bus.Operation   = op_r;
  assign bus.out_illegal = illegal_r;
  assign issue_count     = count_r;

endmodule
